// File: rtl/ace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ace_pkg
// Purpose  : ACE snoop types, ACSNOOP codes and CRRESP bit positions.
// Revision : 1.0
// ============================================================================
package ace_pkg;

    typedef logic [3:0] acsnoop_t;
    typedef logic [4:0] crresp_t;

    localparam acsnoop_t c_ac_read_once              = 4'b0000;
    localparam acsnoop_t c_ac_read_shared            = 4'b0001;
    localparam acsnoop_t c_ac_read_clean             = 4'b0010;
    localparam acsnoop_t c_ac_read_not_shared_dirty  = 4'b0011;
    localparam acsnoop_t c_ac_read_unique            = 4'b0111;
    localparam acsnoop_t c_ac_clean_shared           = 4'b1000;
    localparam acsnoop_t c_ac_clean_invalid          = 4'b1001;
    localparam acsnoop_t c_ac_make_invalid           = 4'b1101;

    // CRRESP = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    localparam int unsigned c_cr_data_transfer = 0;
    localparam int unsigned c_cr_error         = 1;
    localparam int unsigned c_cr_pass_dirty    = 2;
    localparam int unsigned c_cr_is_shared     = 3;
    localparam int unsigned c_cr_was_unique    = 4;

endpackage
`default_nettype wire

// File: rtl/ace_snoop_decision.sv
`default_nettype none
// ============================================================================
// Module   : ace_snoop_decision
// Purpose  : Combinational snoop response / state-update decision from lookup.
// Revision : 1.0
// ============================================================================
module ace_snoop_decision
    import ace_pkg::*;
(
    input  acsnoop_t snoop_i,
    input  logic     hit_i,
    input  logic     dirty_i,
    input  logic     shared_i,
    output crresp_t  crresp_o,
    output logic     needs_data_o,
    output logic     needs_upd_o,
    output logic     inval_o
);

    always_comb begin
        crresp_o    = '0;
        needs_upd_o = 1'b0;
        inval_o     = 1'b0;
        case (snoop_i)
            c_ac_read_once: begin
                if (hit_i) begin
                    crresp_o[c_cr_data_transfer] = 1'b1;
                    crresp_o[c_cr_is_shared]     = 1'b1;
                    crresp_o[c_cr_was_unique]    = !shared_i;
                end
            end
            c_ac_read_shared, c_ac_read_clean, c_ac_read_not_shared_dirty: begin
                if (hit_i) begin
                    crresp_o[c_cr_data_transfer] = 1'b1;
                    crresp_o[c_cr_is_shared]     = 1'b1;
                    crresp_o[c_cr_pass_dirty]    = dirty_i;
                    crresp_o[c_cr_was_unique]    = !shared_i;
                    needs_upd_o                  = dirty_i;
                end
            end
            c_ac_read_unique: begin
                if (hit_i) begin
                    crresp_o[c_cr_data_transfer] = 1'b1;
                    crresp_o[c_cr_pass_dirty]    = dirty_i;
                    crresp_o[c_cr_was_unique]    = !shared_i;
                    needs_upd_o                  = 1'b1;
                    inval_o                      = 1'b1;
                end
            end
            c_ac_clean_invalid: begin
                if (hit_i) begin
                    crresp_o[c_cr_data_transfer] = dirty_i;
                    crresp_o[c_cr_pass_dirty]    = dirty_i;
                    needs_upd_o                  = 1'b1;
                    inval_o                      = 1'b1;
                end
            end
            c_ac_clean_shared: begin
                if (hit_i && dirty_i) begin
                    crresp_o[c_cr_data_transfer] = 1'b1;
                    crresp_o[c_cr_pass_dirty]    = 1'b1;
                    crresp_o[c_cr_is_shared]     = 1'b1;
                    needs_upd_o                  = 1'b1;
                end
            end
            c_ac_make_invalid: begin
                if (hit_i) begin
                    needs_upd_o = 1'b1;
                    inval_o     = 1'b1;
                end
            end
            // Unsupported snoop types are flagged regardless of lookup outcome.
            default: crresp_o[c_cr_error] = 1'b1;
        endcase
    end

    assign needs_data_o = crresp_o[c_cr_data_transfer];

endmodule
`default_nettype wire

// File: rtl/ace_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : ace_snoop_responder
// Purpose  : ACE snoop responder: AC -> cache lookup -> optional state update
//            -> CR response -> optional CD line transfer.
//            ACE_SNOOP_RESP_PARALLEL_EN: drive CR and CD concurrently.
// Revision : 1.0
// ============================================================================
module ace_snoop_responder
    import ace_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned CD_DATA_WIDTH    = 64,
    parameter int unsigned CACHE_LINE_WIDTH = 512
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ac_valid_i,
    output logic                        ac_ready_o,
    input  logic [ADDR_WIDTH-1:0]       ac_addr_i,
    input  acsnoop_t                    ac_snoop_i,
    output logic                        cr_valid_o,
    input  logic                        cr_ready_i,
    output crresp_t                     cr_resp_o,
    output logic                        cd_valid_o,
    input  logic                        cd_ready_i,
    output logic [CD_DATA_WIDTH-1:0]    cd_data_o,
    output logic                        cd_last_o,
    output logic                        lookup_req_o,
    input  logic                        lookup_gnt_i,
    output logic [ADDR_WIDTH-1:0]       lookup_addr_o,
    input  logic                        lookup_rvalid_i,
    input  logic                        lookup_hit_i,
    input  logic                        lookup_dirty_i,
    input  logic                        lookup_shared_i,
    input  logic [CACHE_LINE_WIDTH-1:0] lookup_data_i,
    output logic                        upd_valid_o,
    input  logic                        upd_ready_i,
    output logic [ADDR_WIDTH-1:0]       upd_addr_o,
    output logic                        upd_inval_o
);

    localparam int unsigned c_cd_beats    = CACHE_LINE_WIDTH / CD_DATA_WIDTH;
    localparam int unsigned c_beat_w      = (c_cd_beats > 1) ? $clog2(c_cd_beats) : 1;
    localparam int unsigned c_offset_bits = $clog2(CACHE_LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] c_line_mask =
        {{(ADDR_WIDTH - c_offset_bits){1'b1}}, {c_offset_bits{1'b0}}};
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_cd_beats - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_RESP   = 3'd4,
        S_DATA   = 3'd5
    } state_t;

    state_t                      r_state;
    logic                        r_ac_ready;
    logic                        r_lookup_req;
    logic                        r_cr_valid;
    crresp_t                     r_cr_resp;
    logic                        r_cd_valid;
    logic [c_beat_w-1:0]         r_beat;
    logic                        r_upd_valid;
    logic                        r_upd_inval;
    logic                        r_needs_data;
    acsnoop_t                    r_snoop;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [CACHE_LINE_WIDTH-1:0] r_line;
`ifdef ACE_SNOOP_RESP_PARALLEL_EN
    logic                        r_cr_done;
    logic                        r_cd_done;
    logic                        w_cr_fire;
    logic                        w_cd_fire;
`endif

    crresp_t w_crresp;
    logic    w_needs_data;
    logic    w_needs_upd;
    logic    w_inval;
    logic    w_last;
    logic [ADDR_WIDTH-1:0]    w_ac_addr_aligned;
    logic [CD_DATA_WIDTH-1:0] w_beats [c_cd_beats];

    ace_snoop_decision u_decision (
        .snoop_i      (r_snoop),
        .hit_i        (lookup_hit_i),
        .dirty_i      (lookup_dirty_i),
        .shared_i     (lookup_shared_i),
        .crresp_o     (w_crresp),
        .needs_data_o (w_needs_data),
        .needs_upd_o  (w_needs_upd),
        .inval_o      (w_inval)
    );

    for (genvar gi = 0; gi < c_cd_beats; gi++) begin : g_beat_slice
        assign w_beats[gi] = r_line[gi*CD_DATA_WIDTH +: CD_DATA_WIDTH];
    end

    assign w_ac_addr_aligned = ac_addr_i & c_line_mask;
    assign w_last            = (r_beat == c_last_beat);

`ifdef ACE_SNOOP_RESP_PARALLEL_EN
    assign w_cr_fire = r_cr_valid && cr_ready_i;
    assign w_cd_fire = r_cd_valid && cd_ready_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_ac_ready   <= 1'b0;
            r_lookup_req <= 1'b0;
            r_cr_valid   <= 1'b0;
            r_cr_resp    <= '0;
            r_cd_valid   <= 1'b0;
            r_beat       <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_inval  <= 1'b0;
            r_needs_data <= 1'b0;
            r_snoop      <= '0;
            r_addr       <= '0;
            r_line       <= '0;
`ifdef ACE_SNOOP_RESP_PARALLEL_EN
            r_cr_done    <= 1'b0;
            r_cd_done    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ac_ready <= 1'b1;
                    if (ac_valid_i && r_ac_ready) begin
                        r_addr       <= w_ac_addr_aligned;
                        r_snoop      <= ac_snoop_i;
                        r_ac_ready   <= 1'b0;
                        r_lookup_req <= 1'b1;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_gnt_i) begin
                        r_lookup_req <= 1'b0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lookup_rvalid_i) begin
                        r_line       <= lookup_data_i;
                        r_cr_resp    <= w_crresp;
                        r_needs_data <= w_needs_data;
                        r_upd_inval  <= w_inval;
                        if (w_needs_upd) begin
                            r_upd_valid <= 1'b1;
                            r_state     <= S_UPDATE;
                        end else begin
                            r_cr_valid  <= 1'b1;
                            r_state     <= S_RESP;
`ifdef ACE_SNOOP_RESP_PARALLEL_EN
                            r_cd_valid  <= w_needs_data;
                            r_cr_done   <= 1'b0;
                            r_cd_done   <= !w_needs_data;
`endif
                        end
                    end
                end
                // CR is held back until the cache state change has been accepted.
                S_UPDATE: begin
                    if (upd_ready_i) begin
                        r_upd_valid <= 1'b0;
                        r_cr_valid  <= 1'b1;
                        r_state     <= S_RESP;
`ifdef ACE_SNOOP_RESP_PARALLEL_EN
                        r_cd_valid  <= r_needs_data;
                        r_cr_done   <= 1'b0;
                        r_cd_done   <= !r_needs_data;
`endif
                    end
                end
`ifdef ACE_SNOOP_RESP_PARALLEL_EN
                S_RESP: begin
                    if (w_cr_fire) begin
                        r_cr_valid <= 1'b0;
                        r_cr_done  <= 1'b1;
                    end
                    if (w_cd_fire) begin
                        if (w_last) begin
                            r_beat     <= '0;
                            r_cd_valid <= 1'b0;
                            r_cd_done  <= 1'b1;
                        end else begin
                            r_beat <= r_beat + c_beat_w'(1);
                        end
                    end
                    if ((r_cr_done || w_cr_fire) && (r_cd_done || (w_cd_fire && w_last))) begin
                        r_ac_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
`else
                S_RESP: begin
                    if (cr_ready_i) begin
                        r_cr_valid <= 1'b0;
                        if (r_needs_data) begin
                            r_cd_valid <= 1'b1;
                            r_state    <= S_DATA;
                        end else begin
                            r_ac_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (cd_ready_i) begin
                        if (w_last) begin
                            r_beat     <= '0;
                            r_cd_valid <= 1'b0;
                            r_ac_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + c_beat_w'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ac_ready_o    = r_ac_ready;
    assign lookup_req_o  = r_lookup_req;
    assign lookup_addr_o = r_addr;
    assign upd_valid_o   = r_upd_valid;
    assign upd_addr_o    = r_addr;
    assign upd_inval_o   = r_upd_inval;
    assign cr_valid_o    = r_cr_valid;
    assign cr_resp_o     = r_cr_resp;
    assign cd_valid_o    = r_cd_valid;
    assign cd_data_o     = w_beats[r_beat];
    assign cd_last_o     = r_cd_valid && w_last;

endmodule
`default_nettype wire

// File: tb/tb_ace_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ace_snoop_responder
// Purpose  : Directed and randomized snoops checked against a rule-level model.
// Revision : 1.0
// ============================================================================
module tb_ace_snoop_responder;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 512;
    localparam int NB = LW / DW;

    typedef struct packed {
        logic [4:0] resp;
        logic       data;
        logic       upd;
        logic       inval;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ac_valid;
    logic          ac_ready;
    logic [AW-1:0] ac_addr;
    logic [3:0]    ac_snoop;
    logic          cr_valid;
    logic          cr_ready;
    logic [4:0]    cr_resp;
    logic          cd_valid;
    logic          cd_ready;
    logic [DW-1:0] cd_data;
    logic          cd_last;
    logic          lookup_req;
    logic          lookup_gnt;
    logic [AW-1:0] lookup_addr;
    logic          lookup_rvalid;
    logic          lookup_hit;
    logic          lookup_dirty;
    logic          lookup_shared;
    logic [LW-1:0] lookup_data;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic          upd_inval;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ace_snoop_responder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ac_valid_i      (ac_valid),
        .ac_ready_o      (ac_ready),
        .ac_addr_i       (ac_addr),
        .ac_snoop_i      (ac_snoop),
        .cr_valid_o      (cr_valid),
        .cr_ready_i      (cr_ready),
        .cr_resp_o       (cr_resp),
        .cd_valid_o      (cd_valid),
        .cd_ready_i      (cd_ready),
        .cd_data_o       (cd_data),
        .cd_last_o       (cd_last),
        .lookup_req_o    (lookup_req),
        .lookup_gnt_i    (lookup_gnt),
        .lookup_addr_o   (lookup_addr),
        .lookup_rvalid_i (lookup_rvalid),
        .lookup_hit_i    (lookup_hit),
        .lookup_dirty_i  (lookup_dirty),
        .lookup_shared_i (lookup_shared),
        .lookup_data_i   (lookup_data),
        .upd_valid_o     (upd_valid),
        .upd_ready_i     (upd_ready),
        .upd_addr_o      (upd_addr),
        .upd_inval_o     (upd_inval)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [4:0] resp, input logic upd, input logic inval);
        exp_t e;
        e.resp  = resp;
        e.data  = resp[0];
        e.upd   = upd;
        e.inval = inval;
        return e;
    endfunction

    // Response model written from the snoop rules: reads hand over the line,
    // only ReadOnce never passes dirtiness, only ReadUnique drops IsShared.
    function automatic exp_t model(input logic [3:0] s, input logic hit, input logic dirty,
                                   input logic shared);
        exp_t e;
        bit   rd;
        bit   known;
        e     = '0;
        rd    = (s inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7});
        known = rd || (s inside {4'h8, 4'h9, 4'hD});
        if (!known) begin
            e.resp = 5'b00010;
        end else if (hit) begin
            if (rd) begin
                e.resp[0] = 1'b1;
                e.resp[4] = !shared;
                e.resp[3] = (s != 4'h7);
                e.resp[2] = dirty && (s != 4'h0);
                e.inval   = (s == 4'h7);
                e.upd     = (s == 4'h7) || (dirty && (s != 4'h0));
            end else if (s == 4'h8) begin
                if (dirty) begin
                    e.resp = 5'b01101;
                    e.upd  = 1'b1;
                end
            end else if (s == 4'h9) begin
                e.resp[0] = dirty;
                e.resp[2] = dirty;
                e.upd     = 1'b1;
                e.inval   = 1'b1;
            end else begin
                e.upd   = 1'b1;
                e.inval = 1'b1;
            end
        end
        e.data = e.resp[0];
        return e;
    endfunction

    task automatic run_snoop(input logic [63:0] addr, input logic [3:0] snoop, input logic hit,
                             input logic dirty, input logic shared, input logic [LW-1:0] line,
                             input exp_t e, input int gnt_d, input int rv_d, input int upd_d,
                             input int cr_d, input int cd_mode, input int abort_beat);
        logic [63:0] la;
        int          b;
        int          cyc;
        logic        rdy;
        la  = addr & ~64'h3f;
        cyc = 0;
        while (ac_ready !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        check("ac_ready_idle", ac_ready, 1);
        ac_valid = 1'b1;
        ac_addr  = addr;
        ac_snoop = snoop;
        step();
        ac_valid = 1'b0;
        ac_addr  = {$urandom, $urandom};
        ac_snoop = 4'($urandom);
        check("ac_ready_busy", ac_ready, 0);
        repeat (gnt_d) begin
            check("lookup_req_hold", lookup_req, 1);
            step();
        end
        check("lookup_req", lookup_req, 1);
        check("lookup_addr", lookup_addr, la);
        lookup_gnt = 1'b1;
        step();
        lookup_gnt = 1'b0;
        check("lookup_req_drop", lookup_req, 0);
        repeat (rv_d) begin
            check("cr_early", cr_valid, 0);
            step();
        end
        lookup_rvalid = 1'b1;
        lookup_hit    = hit;
        lookup_dirty  = dirty;
        lookup_shared = shared;
        lookup_data   = line;
        step();
        lookup_rvalid = 1'b0;
        lookup_hit    = 1'($urandom);
        lookup_dirty  = 1'($urandom);
        lookup_shared = 1'($urandom);
        for (int k = 0; k < LW / 32; k++) lookup_data[k*32 +: 32] = $urandom;
        if (e.upd) begin
            repeat (upd_d) begin
                check("upd_valid_hold", upd_valid, 1);
                check("cr_before_upd", cr_valid, 0);
                step();
            end
            check("upd_valid", upd_valid, 1);
            check("upd_addr", upd_addr, la);
            check("upd_inval", upd_inval, e.inval);
            check("cr_before_upd", cr_valid, 0);
            upd_ready = 1'b1;
            step();
            upd_ready = 1'b0;
        end
        check("upd_idle", upd_valid, 0);
        repeat (cr_d) begin
            check("cr_valid_hold", cr_valid, 1);
            check("cr_resp_hold", cr_resp, e.resp);
            check("cd_before_cr", cd_valid, 0);
            step();
        end
        check("cr_valid", cr_valid, 1);
        check("cr_resp", cr_resp, e.resp);
        check("cd_before_cr", cd_valid, 0);
        cr_ready = 1'b1;
        step();
        cr_ready = 1'b0;
        check("cr_drop", cr_valid, 0);
        if (e.data) begin
            b   = 0;
            cyc = 0;
            while (b < NB && cyc < 64) begin
                check("cd_valid", cd_valid, 1);
                check("cd_data", cd_data, line[b*DW +: DW]);
                check("cd_last", cd_last, (b == NB - 1));
                if (b == abort_beat) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check("rst_cr_valid", cr_valid, 0);
                    check("rst_cd_valid", cd_valid, 0);
                    check("rst_upd_valid", upd_valid, 0);
                    check("rst_lookup_req", lookup_req, 0);
                    check("rst_ac_ready", ac_ready, 0);
                    step();
                    check("rst_release_ac_ready", ac_ready, 1);
                    return;
                end
                case (cd_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 2 == 0);
                    default: rdy = 1'($urandom);
                endcase
                cd_ready = rdy;
                step();
                cd_ready = 1'b0;
                if (rdy) b++;
                cyc++;
            end
            check("cd_beats", b, NB);
        end
        check("cd_idle", cd_valid, 0);
        check("ac_ready_back", ac_ready, 1);
    endtask

    initial begin
        logic [LW-1:0] line;
        logic [3:0]    s;
        logic          h, d, sh;
        rst           = 1'b1;
        ac_valid      = 1'b0;
        ac_addr       = '0;
        ac_snoop      = '0;
        cr_ready      = 1'b0;
        cd_ready      = 1'b0;
        lookup_gnt    = 1'b0;
        lookup_rvalid = 1'b0;
        lookup_hit    = 1'b0;
        lookup_dirty  = 1'b0;
        lookup_shared = 1'b0;
        lookup_data   = '0;
        upd_ready     = 1'b0;
        repeat (3) step();
        check("rst_ac_ready", ac_ready, 0);
        check("rst_cr_valid", cr_valid, 0);
        check("rst_cd_valid", cd_valid, 0);
        check("rst_lookup_req", lookup_req, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_cr_resp", cr_resp, 0);
        check("rst_cd_data", cd_data, 0);
        check("rst_cd_last", cd_last, 0);
        rst = 1'b0;
        step();
        check("post_rst_ac_ready", ac_ready, 1);

        for (int i = 0; i < NB; i++) line[i*DW +: DW] = 64'(i);
        // ReadShared, hit dirty shared
        run_snoop(64'h1040, 4'b0001, 1'b1, 1'b1, 1'b1, line, mk(5'b01101, 1'b1, 1'b0),
                  0, 0, 0, 0, 0, -1);
        for (int k = 0; k < LW / 32; k++) line[k*32 +: 32] = $urandom;
        // ReadOnce, hit clean unique
        run_snoop(64'h2000_0088, 4'b0000, 1'b1, 1'b0, 1'b0, line, mk(5'b11001, 1'b0, 1'b0),
                  0, 0, 0, 0, 0, -1);
        // MakeInvalid hit dirty, then misses
        run_snoop(64'h3fff, 4'b1101, 1'b1, 1'b1, 1'b0, line, mk(5'b00000, 1'b1, 1'b1),
                  1, 1, 1, 0, 0, -1);
        run_snoop(64'h4444, 4'b0001, 1'b0, 1'b1, 1'b0, line, mk(5'b00000, 1'b0, 1'b0),
                  0, 0, 0, 0, 0, -1);
        run_snoop(64'h5555, 4'b0111, 1'b0, 1'b1, 1'b0, line, mk(5'b00000, 1'b0, 1'b0),
                  0, 2, 0, 1, 0, -1);
        // Unsupported code
        run_snoop(64'h6000, 4'b0101, 1'b1, 1'b1, 1'b0, line, mk(5'b00010, 1'b0, 1'b0),
                  0, 0, 0, 0, 0, -1);
        // Backpressure: CR held 5 cycles, CD ready toggling
        for (int k = 0; k < LW / 32; k++) line[k*32 +: 32] = $urandom;
        run_snoop(64'h7abc, 4'b0111, 1'b1, 1'b1, 1'b0, line, mk(5'b10101, 1'b1, 1'b1),
                  2, 1, 2, 5, 1, -1);
        // Reset during beat 3
        for (int k = 0; k < LW / 32; k++) line[k*32 +: 32] = $urandom;
        run_snoop(64'h8100, 4'b0010, 1'b1, 1'b0, 1'b1, line, mk(5'b01001, 1'b0, 1'b0),
                  0, 0, 0, 0, 0, 3);

        for (int n = 0; n < 40; n++) begin
            s  = 4'($urandom_range(0, 15));
            h  = 1'($urandom);
            d  = 1'($urandom);
            sh = 1'($urandom);
            if (!(s inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hD})) h = 1'b1;
            for (int k = 0; k < LW / 32; k++) line[k*32 +: 32] = $urandom;
            run_snoop({$urandom, $urandom}, s, h, d, sh, line, model(s, h, d, sh),
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 3), 2, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
